// File: rtl/mod13_checker.sv
// mod13_checker: locks onto a mod-13 count stream and flags skips, repeats and
// out-of-range samples or load data, with error and wrap statistics.
module mod13_checker #(
    parameter int MOD    = 13,
    parameter int LOCK_N = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       cnt_in,
    input  logic             cnt_vld,
    input  logic             ld_in,
    input  logic [3:0]       ld_data,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic             illegal,
    output logic             wrap,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic [3:0]       exp_out
);
    localparam int RW = $clog2(LOCK_N + 1);
    localparam logic [RW-1:0] LN = RW'(LOCK_N);
    localparam logic [3:0] M1 = 4'(MOD - 1);

    typedef enum logic {SYNC, LOCKED} state_t;

    state_t r_state, w_state;
    logic [3:0] r_exp, w_exp, r_prev, w_prev, w_inc;
    logic r_ok, w_ok, w_err, w_ill, w_wrap, w_s_ill, w_d_ill;
    logic [RW-1:0] r_run, w_run, w_run_inc;

    assign w_s_ill = {1'b0, cnt_in} >= 5'(MOD);
    assign w_d_ill = {1'b0, ld_data} >= 5'(MOD);
    assign w_inc = (cnt_in == M1) ? 4'd0 : cnt_in + 4'd1;
    assign w_run_inc = (r_run >= LN) ? LN : r_run + 1'b1;

    // The sample is judged against the old expectation before any load applies.
    always_comb begin
        w_state = r_state;
        w_exp = r_exp;
        w_ok = r_ok;
        w_run = r_run;
        w_prev = r_prev;
        w_err = 1'b0;
        w_ill = 1'b0;
        w_wrap = 1'b0;
        if (cnt_vld) begin
            w_prev = cnt_in;
            if (w_s_ill) begin
                w_ill = 1'b1;
                w_err = (r_state == LOCKED);
                w_state = SYNC;
                w_run = '0;
                w_ok = 1'b0;
            end else if (r_state == LOCKED) begin
                w_exp = w_inc;
                if (cnt_in == r_exp) begin
                    w_wrap = (r_prev == M1) && (cnt_in == 4'd0);
                end else begin
                    w_err = 1'b1;
                    w_state = SYNC;
                    w_run = RW'(1);
                end
            end else begin
                w_run = (r_ok && cnt_in == r_exp) ? w_run_inc : RW'(1);
                w_exp = w_inc;
                w_ok = 1'b1;
                if (w_run >= LN) w_state = LOCKED;
            end
        end
        if (ld_in) begin
            if (w_d_ill) begin
                w_ill = 1'b1;
                w_state = SYNC;
                w_run = '0;
                w_ok = 1'b0;
            end else begin
                w_exp = ld_data;
                w_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SYNC;
            r_exp <= '0;
            r_ok <= 1'b0;
            r_run <= '0;
            r_prev <= '0;
            err <= 1'b0;
            illegal <= 1'b0;
            wrap <= 1'b0;
            err_cnt <= '0;
            wrap_cnt <= '0;
        end else begin
            r_state <= w_state;
            r_exp <= w_exp;
            r_ok <= w_ok;
            r_run <= w_run;
            r_prev <= w_prev;
            err <= w_err;
            illegal <= w_ill;
            wrap <= w_wrap;
            if (clr) err_cnt <= CNT_W'(w_err);
            else if (w_err && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
            wrap_cnt <= clr ? CNT_W'(w_wrap) : wrap_cnt + CNT_W'(w_wrap);
        end
    end

    assign locked = (r_state == LOCKED);
    assign exp_out = r_exp;
endmodule

// File: tb/tb_mod13_checker.sv
// tb_mod13_checker: directed vectors with a scoreboard queue of expected outputs.
module tb_mod13_checker;
    logic clk = 0, rst = 1, cnt_vld = 0, ld_in = 0, clr = 0;
    logic [3:0] cnt_in = 0, ld_data = 0;
    logic locked, err, illegal, wrap;
    logic [7:0] err_cnt, wrap_cnt;
    logic [3:0] exp_out;
    int errors = 0, checks = 0, vec = 0;

    typedef struct {
        logic lk, er, il, wr;
        logic [7:0] ec, wc;
        logic [3:0] ex;
        int id;
    } exp_t;
    exp_t q[$];

    mod13_checker dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_vld(cnt_vld), .ld_in(ld_in),
        .ld_data(ld_data), .clr(clr), .locked(locked), .err(err), .illegal(illegal),
        .wrap(wrap), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt), .exp_out(exp_out)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, v, input int c, input logic l, input int d,
                        input logic cl, lk, er, il, wr, input int ec, wc, ex);
        exp_t e;
        @(negedge clk);
        rst = r; cnt_vld = v; cnt_in = 4'(c); ld_in = l; ld_data = 4'(d); clr = cl;
        @(posedge clk);
        #1;
        e.lk = lk; e.er = er; e.il = il; e.wr = wr;
        e.ec = 8'(ec); e.wc = 8'(wc); e.ex = 4'(ex); e.id = vec;
        q.push_back(e);
        vec++;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({locked, err, illegal, wrap, err_cnt, wrap_cnt, exp_out} !==
                {e.lk, e.er, e.il, e.wr, e.ec, e.wc, e.ex}) begin
                errors++;
                $display("FAIL vec%0d: got lk=%b er=%b il=%b wr=%b ec=%0d wc=%0d ex=%0d, want lk=%b er=%b il=%b wr=%b ec=%0d wc=%0d ex=%0d",
                         e.id, locked, err, illegal, wrap, err_cnt, wrap_cnt, exp_out,
                         e.lk, e.er, e.il, e.wr, e.ec, e.wc, e.ex);
            end
        end
    end

    initial begin
        int v;
        step(1,0,0,0,0,0, 0,0,0,0, 0,0,0);
        step(1,0,0,0,0,0, 0,0,0,0, 0,0,0);
        for (int i = 0; i < 30; i++) begin
            v = i % 13;
            step(0,1,v,0,0,0, i >= 1, 0, 0, (v == 0 && i > 0), 0, i / 13, (v == 12) ? 0 : v + 1);
        end
        step(0,1,4,0,0,0, 1,0,0,0, 0,2,5);
        step(0,1,5,0,0,0, 1,0,0,0, 0,2,6);
        step(0,1,7,0,0,0, 0,1,0,0, 1,2,8);
        step(0,1,8,0,0,0, 1,0,0,0, 1,2,9);
        step(0,1,9,0,0,0, 1,0,0,0, 1,2,10);
        step(0,1,10,1,3,0, 1,0,0,0, 1,2,3);
        step(0,1,3,0,0,0, 1,0,0,0, 1,2,4);
        step(0,1,4,1,3,0, 1,0,0,0, 1,2,3);
        step(0,1,4,0,0,0, 0,1,0,0, 2,2,5);
        step(0,1,5,0,0,0, 1,0,0,0, 2,2,6);
        step(0,1,6,0,0,0, 1,0,0,0, 2,2,7);
        step(0,0,0,0,0,0, 1,0,0,0, 2,2,7);
        step(0,0,0,1,13,0, 0,0,1,0, 2,2,7);
        step(0,1,7,0,0,0, 0,0,0,0, 2,2,8);
        step(0,1,8,0,0,0, 1,0,0,0, 2,2,9);
        step(0,1,13,0,0,0, 0,1,1,0, 3,2,9);
        step(0,1,2,0,0,0, 0,0,0,0, 3,2,3);
        step(0,1,3,0,0,0, 1,0,0,0, 3,2,4);
        step(0,1,14,1,15,0, 0,1,1,0, 4,2,4);
        step(0,1,0,0,0,0, 0,0,0,0, 4,2,1);
        step(0,1,1,0,0,0, 1,0,0,0, 4,2,2);
        for (int k = 1; k <= 300; k++) begin
            step(0,1,5,0,0,0, 0,1,0,0, (4 + k > 255) ? 255 : 4 + k, 2, 6);
            step(0,1,6,0,0,0, 1,0,0,0, (4 + k > 255) ? 255 : 4 + k, 2, 7);
        end
        step(0,1,5,0,0,1, 0,1,0,0, 1,0,6);
        step(0,0,0,0,0,1, 0,0,0,0, 0,0,6);
        step(0,1,6,0,0,0, 1,0,0,0, 0,0,7);
        step(1,1,7,0,0,0, 0,0,0,0, 0,0,0);
        step(0,1,3,0,0,0, 0,0,0,0, 0,0,4);
        step(0,1,4,0,0,0, 1,0,0,0, 0,0,5);
        @(negedge clk);
        rst = 0; cnt_vld = 0; ld_in = 0; clr = 0;
        for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses left unchecked, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
